sr_deser_rx: RTL and testbench
==============================

// Module: sr_deser_rx
// PURPOSE
//  Framed serial receiver: the far end of a link driven by the universal shift register in shift mode.
//  Detects start bit, deserialises WIDTH data bits (LSB- or MSB-first), checks stop bit.
//  Presents a parallel word with a one-cycle valid pulse. Sits between the serial line and parallel consumers.
// PARAMETERS
//  WIDTH  4  data bits per frame (>=2); sets o_data width and the bit-counter range
// PORTS
//  in_clk   in   1      single clock; all state updates on posedge
//  in_rst   in   1      synchronous, active-high reset
//  in_en    in   1      bit strobe; line sampled only on cycles with in_en=1
//  in_sd    in   1      serial data line; idles high
//  in_dir   in   1      0: LSB-first (tx shift-right); 1: MSB-first (tx shift-left)
//  o_data   out  WIDTH  last correctly framed word
//  o_valid  out  1      1-cycle pulse: o_data updated with a good frame
//  o_ferr   out  1      1-cycle pulse: stop bit sampled as 0
//  o_busy   out  1      1 while in DATA or STOP
// BEHAVIOUR
//  Reset (in_rst=1 at posedge): state=IDLE, shreg=0, cnt=0, o_data=0, o_valid=0, o_ferr=0, o_busy=0.
//   Reset wins over every other event; mid-frame reset discards the partial frame. No pulse is emitted.
//  Frame on line (one bit per in_en cycle): start(0), WIDTH data bits, stop(1).
//  in_en=0: no state/counter/shreg change; o_valid, o_ferr forced 0 (pulses never stretch).
//  FSM (registered, 3 states):
//   IDLE: in_en & in_sd=0 -> DATA; cnt<=0; dir_q<=in_dir. in_sd=1 stays IDLE.
//   DATA: on in_en shift in_sd into shreg; cnt<=cnt+1.
//     dir_q=0: shreg<={in_sd, shreg[WIDTH-1:1]}. dir_q=1: shreg<={shreg[WIDTH-2:0], in_sd}.
//     After the WIDTH-th data bit (cnt==WIDTH-1) -> STOP.
//   STOP: on in_en: in_sd=1 -> o_data<=shreg, o_valid<=1; in_sd=0 -> o_ferr<=1, o_data unchanged.
//     Either way -> IDLE.
//  in_dir is latched at the start bit; changes mid-frame have no effect on the current frame.
//  Latency: o_valid/o_ferr high for exactly the one cycle after the posedge that sampled the stop bit.
//  Back-to-back: a start bit on the first in_en cycle after STOP is accepted (zero idle bits required).
//  Glitch rule: start bit is a single sample; no mid-bit re-check (in_en is already bit-centred upstream).
//  cnt width is $clog2(WIDTH); it never wraps beyond WIDTH-1 inside DATA.
//  o_busy=1 exactly when state is DATA or STOP; o_data stable except on a good stop bit.
// STRUCTURE
//  Shared package: state encoding localparams ST_IDLE=2'd0, ST_DATA=2'd1, ST_STOP=2'd2; DIR_LSB=0, DIR_MSB=1.
//  Sub-module sipo_shreg #(WIDTH): direction-selectable serial-in shift register (in_clk, in_rst, en, dir, sd -> q).
//  Top holds FSM, bit counter, dir_q latch, output registers. All flops reset synchronously.
// TESTING (WIDTH=4, in_en=1 every cycle unless noted)
//  1. dir=0, line 0,1,1,0,1,1 -> o_data=4'hB, o_valid pulse 1 cycle, o_ferr=0, o_busy low afterwards.
//  2. dir=1, line 0,1,0,1,1,1 -> o_data=4'hB; then dir=1 frame 0,0,1,1,0,0 -> o_ferr pulse, o_data stays 4'hB.
//  3. in_en high every 3rd cycle, dir=0, frame for 4'h6 -> o_data=4'h6; line changes on in_en=0 cycles ignored.
//  4. Reset asserted after 2 data bits -> all outputs 0 next cycle, IDLE; following full frame 4'h9 received correctly.
//  5. Back-to-back frames 4'h3 then 4'hC, no idle bit between -> two o_valid pulses, 6 in_en cycles apart.
//  6. in_dir toggled mid-frame (latched 0) -> word assembled LSB-first; line held 1 in IDLE -> no pulses, o_busy=0.

Source files
------------

// File: rtl/sr_deser_rx_pkg.sv
// Shared definitions for the framed serial receiver: state encoding and
// direction codes.
package sr_deser_rx_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_DATA = ST_DATA,
    S_STOP = ST_STOP
  } state_t;
endpackage

// File: rtl/sr_deser_rx_if.sv
// Line-side inputs and parallel-side outputs of the receiver.
// The master drives the serial line; the slave is the receiver.
interface sr_deser_rx_if #(parameter int WIDTH = 4);
  logic             in_en;
  logic             in_sd;
  logic             in_dir;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_ferr;
  logic             o_busy;

  modport master (output in_en, in_sd, in_dir,
                  input  o_data, o_valid, o_ferr, o_busy);
  modport slave  (input  in_en, in_sd, in_dir,
                  output o_data, o_valid, o_ferr, o_busy);
endinterface

// File: rtl/sr_deser_rx_sipo.sv
// Direction-selectable serial-in parallel-out shift register.
// LSB-first shifts toward bit 0, so the first bit received ends up in q[0].
module sipo_shreg
  import sr_deser_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sd,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge in_clk) begin
    if (in_rst)
      q <= '0;
    else if (en) begin
      if (dir == DIR_MSB)
        q <= {q[WIDTH-2:0], sd};
      else
        q <= {sd, q[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/sr_deser_rx.sv
// Framed serial receiver: start bit, WIDTH data bits, stop bit; emits a
// one-cycle valid or framing-error pulse after the stop bit is sampled.
module sr_deser_rx
  import sr_deser_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic           in_clk,
  input logic           in_rst,
  sr_deser_rx_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            dir_q;
  logic [WIDTH-1:0] shreg;
  logic            shift_en;

  assign shift_en = bus.in_en && (state == S_DATA);

  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .en     (shift_en),
    .dir    (dir_q),
    .sd     (bus.in_sd),
    .q      (shreg)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      dir_q       <= DIR_LSB;
      bus.o_data  <= '0;
      bus.o_valid <= 1'b0;
      bus.o_ferr  <= 1'b0;
      bus.o_busy  <= 1'b0;
    end else begin
      bus.o_valid <= 1'b0;
      bus.o_ferr  <= 1'b0;
      if (bus.in_en) begin
        case (state)
          S_IDLE: if (!bus.in_sd) begin
            state      <= S_DATA;
            cnt        <= '0;
            dir_q      <= bus.in_dir;
            bus.o_busy <= 1'b1;
          end
          S_DATA: begin
            // hold the counter at the last bit so it never wraps
            if (cnt == CW'(WIDTH-1))
              state <= S_STOP;
            else
              cnt <= cnt + 1'b1;
          end
          S_STOP: begin
            if (bus.in_sd) begin
              bus.o_data  <= shreg;
              bus.o_valid <= 1'b1;
            end else begin
              bus.o_ferr  <= 1'b1;
            end
            state      <= S_IDLE;
            bus.o_busy <= 1'b0;
          end
          default: begin
            state      <= S_IDLE;
            bus.o_busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sr_deser_rx.sv
// Self-checking bench for sr_deser_rx: directed scenarios plus a randomized
// line checked against a frame-level reference model.
module tb_sr_deser_rx;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sr_deser_rx_if #(.WIDTH(W)) bus();

  sr_deser_rx #(.WIDTH(W)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus.slave)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // reference model: collects the data bits of a frame, builds the word arithmetically
  bit             m_fr;
  bit             m_q[$];
  bit             m_dir;
  logic [W-1:0]   m_data;
  bit             m_valid, m_ferr, m_busy;

  function automatic logic [W-1:0] assemble();
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++)
      w[m_dir ? (W-1-i) : i] = m_q[i];
    return w;
  endfunction

  task automatic tick(input bit en, input bit sd, input bit dir, input bit r);
    @(negedge clk);
    bus.in_en = en; bus.in_sd = sd; bus.in_dir = dir; rst = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_fr = 0; m_q.delete(); m_data = '0; m_valid = 0; m_ferr = 0;
    end else begin
      m_valid = 0; m_ferr = 0;
      if (en) begin
        if (!m_fr) begin
          if (!sd) begin m_fr = 1; m_q.delete(); m_dir = dir; end
        end else if (m_q.size() < W) begin
          m_q.push_back(sd);
        end else begin
          if (sd) begin m_data = assemble(); m_valid = 1; end
          else m_ferr = 1;
          m_fr = 0;
        end
      end
    end
    m_busy = m_fr;
    #1;
  endtask

  task automatic send(input logic [W-1:0] w, input bit dir, input bit stop);
    tick(1, 0, dir, 0);
    for (int i = 0; i < W; i++)
      tick(1, dir ? w[W-1-i] : w[i], dir, 0);
    tick(1, stop, dir, 0);
  endtask

  task automatic test_reset();
    tick(0, 1, 0, 1);
    total++; if (bus.o_data !== '0) $display("FAIL reset_data: got %h want 0", bus.o_data); else passed++;
    total++; if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.o_valid); else passed++;
    total++; if (bus.o_ferr !== 1'b0) $display("FAIL reset_ferr: got %b want 0", bus.o_ferr); else passed++;
    total++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.o_busy); else passed++;
    tick(0, 1, 0, 0);
  endtask

  task automatic test_lsb();
    bit line[6] = '{0, 1, 1, 0, 1, 1};
    for (int i = 0; i < 6; i++) tick(1, line[i], 0, 0);
    total++; if (bus.o_valid !== 1'b1 || bus.o_data !== 4'hB)
      $display("FAIL lsb_word: got v=%b d=%h want v=1 d=b", bus.o_valid, bus.o_data); else passed++;
    total++; if (bus.o_ferr !== 1'b0) $display("FAIL lsb_ferr: got %b want 0", bus.o_ferr); else passed++;
    tick(1, 1, 0, 0);
    total++; if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0)
      $display("FAIL lsb_after: got v=%b busy=%b want 0 0", bus.o_valid, bus.o_busy); else passed++;
  endtask

  task automatic test_msb_ferr();
    bit good[6] = '{0, 1, 0, 1, 1, 1};
    bit bad[6]  = '{0, 0, 1, 1, 0, 0};
    for (int i = 0; i < 6; i++) tick(1, good[i], 1, 0);
    total++; if (bus.o_valid !== 1'b1 || bus.o_data !== 4'hB)
      $display("FAIL msb_word: got v=%b d=%h want v=1 d=b", bus.o_valid, bus.o_data); else passed++;
    for (int i = 0; i < 6; i++) tick(1, bad[i], 1, 0);
    total++; if (bus.o_ferr !== 1'b1 || bus.o_valid !== 1'b0)
      $display("FAIL ferr_pulse: got f=%b v=%b want f=1 v=0", bus.o_ferr, bus.o_valid); else passed++;
    total++; if (bus.o_data !== 4'hB) $display("FAIL ferr_data_hold: got %h want b", bus.o_data); else passed++;
    tick(1, 1, 1, 0);
    total++; if (bus.o_ferr !== 1'b0) $display("FAIL ferr_one_cycle: got %b want 0", bus.o_ferr); else passed++;
  endtask

  task automatic test_sparse_en();
    bit line[6] = '{0, 0, 1, 1, 0, 1};
    bit seen_early = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1, line[i], 0, 0);
      if (i < 5) begin
        tick(0, 1'($urandom), 1'($urandom), 0);
        seen_early |= bus.o_valid | bus.o_ferr;
        tick(0, 1'($urandom), 1'($urandom), 0);
        seen_early |= bus.o_valid | bus.o_ferr;
      end
    end
    total++; if (bus.o_valid !== 1'b1 || bus.o_data !== 4'h6)
      $display("FAIL sparse_word: got v=%b d=%h want v=1 d=6", bus.o_valid, bus.o_data); else passed++;
    total++; if (seen_early !== 1'b0) $display("FAIL sparse_no_early_pulse: got %b want 0", seen_early); else passed++;
    tick(0, 0, 0, 0);
    total++; if (bus.o_valid !== 1'b0) $display("FAIL sparse_no_stretch: got %b want 0", bus.o_valid); else passed++;
  endtask

  task automatic test_mid_reset();
    tick(1, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 0, 0, 0);
    tick(1, 1, 0, 1);
    total++; if (bus.o_data !== '0 || bus.o_valid !== 1'b0 || bus.o_ferr !== 1'b0 || bus.o_busy !== 1'b0)
      $display("FAIL midrst_outputs: got d=%h v=%b f=%b busy=%b want 0 0 0 0",
               bus.o_data, bus.o_valid, bus.o_ferr, bus.o_busy); else passed++;
    send(4'h9, 0, 1);
    total++; if (bus.o_valid !== 1'b1 || bus.o_data !== 4'h9)
      $display("FAIL midrst_next_frame: got v=%b d=%h want v=1 d=9", bus.o_valid, bus.o_data); else passed++;
  endtask

  task automatic test_back_to_back();
    int t1, t2, pulses = 0;
    send(4'h3, 0, 1);
    t1 = cyc; pulses += int'(bus.o_valid);
    total++; if (bus.o_data !== 4'h3) $display("FAIL b2b_first: got %h want 3", bus.o_data); else passed++;
    send(4'hC, 0, 1);
    t2 = cyc; pulses += int'(bus.o_valid);
    total++; if (bus.o_data !== 4'hC) $display("FAIL b2b_second: got %h want c", bus.o_data); else passed++;
    total++; if (pulses != 2 || (t2 - t1) != 6)
      $display("FAIL b2b_spacing: got pulses=%0d gap=%0d want 2 6", pulses, t2 - t1); else passed++;
  endtask

  task automatic test_dir_toggle();
    logic [W-1:0] w = 4'hA;
    bit bad = 0;
    tick(1, 0, 0, 0);
    for (int i = 0; i < W; i++) tick(1, w[i], ~i[0], 0);
    tick(1, 1, 1, 0);
    total++; if (bus.o_valid !== 1'b1 || bus.o_data !== 4'hA)
      $display("FAIL dir_latch: got v=%b d=%h want v=1 d=a", bus.o_valid, bus.o_data); else passed++;
    for (int i = 0; i < 8; i++) begin
      tick(1, 1, 1'($urandom), 0);
      if (bus.o_valid !== 1'b0 || bus.o_ferr !== 1'b0 || bus.o_busy !== 1'b0) bad = 1;
    end
    total++; if (bad !== 1'b0) $display("FAIL idle_high_quiet: got %b want 0", bad); else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int n = 0; n < 600; n++) begin
      tick($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), $urandom_range(0, 79) == 0);
      if (bus.o_valid !== m_valid || bus.o_ferr !== m_ferr ||
          bus.o_busy !== m_busy || bus.o_data !== m_data) begin
        if (errs < 5)
          $display("FAIL rand_cycle%0d: got v=%b f=%b busy=%b d=%h want v=%b f=%b busy=%b d=%h",
                   n, bus.o_valid, bus.o_ferr, bus.o_busy, bus.o_data, m_valid, m_ferr, m_busy, m_data);
        errs++;
      end
    end
    total++; if (errs != 0) $display("FAIL rand_total: got %0d bad cycles want 0", errs); else passed++;
  endtask

  initial begin
    bus.in_en = 0; bus.in_sd = 1; bus.in_dir = 0; rst = 1;
    test_reset();
    test_lsb();
    test_msb_ferr();
    test_sparse_en();
    test_mid_reset();
    test_back_to_back();
    test_dir_toggle();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
